// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Encoding 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/fs_cell.sv
// One-bit combinational full subtractor used as the serial bit step.
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic br,
  output logic diff,
  output logic br_next
);

  assign diff    = x ^ y ^ br;
  assign br_next = (~x & y) | (~(x ^ y) & br);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin LSB first over WIDTH clock cycles,
// then pulses done for one cycle with difference, borrow-out and signed overflow.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] aSr_q, aSr_d;
  logic [WIDTH-1:0] bSr_q, bSr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             stepDiff, stepBorrow;

  fs_cell u_fsCell (
    .x      (aSr_q[0]),
    .y      (bSr_q[0]),
    .br     (borrow_q),
    .diff   (stepDiff),
    .br_next(stepBorrow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      aSr_q    <= '0;
      bSr_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      aSr_q    <= aSr_d;
      bSr_q    <= bSr_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    aSr_d    = aSr_q;
    bSr_d    = bSr_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    busy     = 1'b0;
    done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SHIFT;
          aSr_d    = a;
          bSr_d    = b;
          borrow_d = bin;
          cnt_d    = '0;
          diff_d   = '0;
          ovf_d    = 1'b0;
        end
      end

      SHIFT: begin
        busy     = 1'b1;
        aSr_d    = aSr_q >> 1;
        bSr_d    = bSr_q >> 1;
        borrow_d = stepBorrow;
        // New bit enters at the MSB so that after WIDTH steps bit 0 sits at the LSB.
        diff_d   = (diff_q >> 1) | (WIDTH'(stepDiff) << (WIDTH - 1));
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          // On the last step the cell sees the operand sign bits and produces the result sign.
          ovf_d   = (aSr_q[0] ^ bSr_q[0]) & (stepDiff ^ aSr_q[0]);
        end
      end

      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign d    = diff_q;
  assign bout = borrow_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, bin8, busy8, done8, bout8, ovf8;
  logic [7:0] a8, b8, d8;
  logic       start1, bin1, busy1, done1, bout1, ovf1;
  logic [0:0] a1, b1, d1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .d(d8), .bout(bout8), .ovf(ovf8)
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .d(d1), .bout(bout1), .ovf(ovf1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Counts rising edges after the capture edge until the edge that samples done high.
  task automatic waitDone(input bit useNarrow, output int edges);
    bit seen;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 40) begin
      @(negedge clk);
      seen = useNarrow ? done1 : done8;
      @(posedge clk);
      edges++;
    end
    if (!seen) checkOutput("doneTimeout", 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb,
                               input logic tbin, input logic [7:0] expD,
                               input logic expBout, input logic expOvf,
                               input string tag);
    int edges;
    @(negedge clk);
    a8 = ta; b8 = tb; bin8 = tbin; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    checkOutput({tag, "_busy"}, 32'(busy8), 32'd1);
    waitDone(1'b0, edges);
    #1;
    checkOutput({tag, "_lat"}, 32'(edges), 32'd9);
    checkOutput({tag, "_d"}, 32'(d8), 32'(expD));
    checkOutput({tag, "_bout"}, 32'(bout8), 32'(expBout));
    checkOutput({tag, "_ovf"}, 32'(ovf8), 32'(expOvf));
    checkOutput({tag, "_idle"}, {30'd0, busy8, done8}, 32'd0);
  endtask

  initial begin
    int edges;
    int extra;

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
    #12;
    checkOutput("rst8", {21'd0, busy8, done8, d8, bout8, ovf8}, 32'd0);
    checkOutput("rst1", {27'd0, busy1, done1, d1, bout1, ovf1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, "v05m03");
    applyStimulus(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, "v00m01");
    applyStimulus(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, "v00bin");
    applyStimulus(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "v80m01");
    applyStimulus(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, "v7FmFF");
    applyStimulus(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "vFFmFF");
    applyStimulus(8'h3C, 8'h5A, 1'b1, 8'hE1, 1'b1, 1'b0, "v3Cm5A");
    applyStimulus(8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1, "vA5m5A");

    // Results hold while idle.
    repeat (3) @(negedge clk);
    checkOutput("hold_d", 32'(d8), 32'h4B);
    checkOutput("hold_ovf", 32'(ovf8), 32'd1);

    // Restart attempt and operand changes while busy.
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 a8 = 8'h10; b8 = 8'h20; bin8 = 1'b1; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    waitDone(1'b0, edges);
    #1;
    checkOutput("busyStart_d", 32'(d8), 32'h02);
    checkOutput("busyStart_bout", 32'(bout8), 32'd0);
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy8 || done8) extra++;
    end
    checkOutput("busyStart_noSecondOp", 32'(extra), 32'd0);

    // Reset in the middle of an operation.
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("midRst_outputs", {21'd0, busy8, done8, d8, bout8, ovf8}, 32'd0);
    start8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstStart_busy", 32'(busy8), 32'd0);
    start8 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) extra++;
    end
    checkOutput("midRst_noDone", 32'(extra), 32'd0);
    applyStimulus(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "afterRst");

    // Start held high: back-to-back operations.
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    waitDone(1'b0, edges);
    #1;
    checkOutput("b2b_first_d", 32'(d8), 32'h0F);
    waitDone(1'b0, edges);
    #1 start8 = 1'b0;
    checkOutput("b2b_period", 32'(edges), 32'd10);
    checkOutput("b2b_second_d", 32'(d8), 32'h0F);

    // WIDTH=1 exhaustive truth table.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      int         diff;
      logic       expD, expBout, expOvf;
      v       = 3'(i);
      diff    = int'(v[2]) - int'(v[1]) - int'(v[0]);
      expD    = (diff < 0) ? 1'((diff + 2)) : 1'(diff);
      expBout = (diff < 0);
      expOvf  = (v[2] != v[1]) && (expD != v[2]);
      @(negedge clk);
      a1 = v[2]; b1 = v[1]; bin1 = v[0]; start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      waitDone(1'b1, edges);
      #1;
      checkOutput($sformatf("w1_%0d_lat", i), 32'(edges), 32'd2);
      checkOutput($sformatf("w1_%0d_d", i), 32'(d1), 32'(expD));
      checkOutput($sformatf("w1_%0d_bout", i), 32'(bout1), 32'(expBout));
      checkOutput($sformatf("w1_%0d_ovf", i), 32'(ovf1), 32'(expOvf));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 1..32.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend, unsigned or two's complement.
REQ-006 b  input  WIDTH  subtrahend.
REQ-007 bin  input  1  borrow-in.
REQ-008 busy  output  1  high while operation in progress (SHIFT or DONE).
REQ-009 done  output  1  one-cycle pulse; d/bout/ovf valid.
REQ-010 d  output  WIDTH  difference.
REQ-011 bout  output  1  unsigned borrow-out.
REQ-012 ovf  output  1  signed overflow flag.

Function
REQ-013 Result SHALL be d = (a - b - bin) mod 2^WIDTH; bout = 1 iff a < b + bin (unsigned); ovf = 1 iff sign(a) != sign(b) and sign(d) != sign(a).
REQ-014 FSM states IDLE, SHIFT, DONE; IDLE->SHIFT on start; SHIFT->DONE after WIDTH bit steps; DONE->IDLE unconditionally after one cycle.
REQ-015 On the start edge in IDLE: a, b captured into shift registers, bin loaded into borrow flip-flop, bit counter cleared, d cleared.
REQ-016 Each SHIFT cycle processes one bit LSB first: diff = x^y^br, br_next = (~x&y) | (~(x^y)&br); diff shifted into d MSB-side so d is correctly aligned after WIDTH steps.
REQ-017 Latency: done high exactly WIDTH+1 clock edges after the start edge; busy high from start edge +1 through the done cycle inclusive.
REQ-018 bout = final borrow flip-flop; ovf computed from captured operand MSBs and final d MSB; both valid when done=1.
REQ-019 d, bout, ovf SHALL hold their last values after DONE until the next accepted start.
REQ-020 start while busy=1 SHALL be ignored (no restart, no queuing); a/b/bin changes during busy SHALL not affect the result.
REQ-021 start held high continuously SHALL begin a new operation in the IDLE cycle after each DONE (back-to-back throughput WIDTH+2 cycles).
REQ-022 Bit counter SHALL be ceil(log2(WIDTH+1)) bits minimum, no wrap within an operation; WIDTH=1 SHALL complete in one SHIFT cycle.

Reset
REQ-023 rst=1 SHALL immediately force state IDLE, busy=0, done=0, d=0, bout=0, ovf=0, counter=0, borrow flip-flop=0, regardless of clk.
REQ-024 Reset asserted mid-operation SHALL abort it; no done pulse for that operation; first start after release behaves as from power-up.
REQ-025 start SHALL be ignored while rst=1.

Structure
REQ-026 A shared package SHALL hold the state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH.
REQ-027 One sub-module fs_cell (1-bit combinational full subtractor: x, y, br -> diff, br_next) SHALL be instantiated once for the serial bit step.
REQ-028 State 2'd3 SHALL be treated as illegal and return to IDLE on the next edge.

Verification
REQ-029 WIDTH=8: a=0x05, b=0x03, bin=0, start pulse -> done 9 edges later, d=0x02, bout=0, ovf=0.
REQ-030 WIDTH=8: a=0x00, b=0x01, bin=0 -> d=0xFF, bout=1, ovf=0; a=0x00, b=0x00, bin=1 -> d=0xFF, bout=1.
REQ-031 WIDTH=8: a=0x80, b=0x01, bin=0 -> d=0x7F, bout=0, ovf=1; a=0x7F, b=0xFF -> d=0x80, bout=1, ovf=1.
REQ-032 Start accepted, operands changed and start re-pulsed at cycle 3 -> single done with original result; no second operation.
REQ-033 rst asserted at SHIFT cycle 4 -> all outputs 0 asynchronously, no done; next start yields correct result.
REQ-034 WIDTH=1 build: exhaustive {a,b,bin}=000..111 -> d/bout match full-subtractor truth table, done 2 edges after each start.
